// File: rtl/lcd_bus_receiver.sv
// Receiving end of an HD44780-style 8-bit parallel bus (RS, E, D0..D7).
// Qualifies E falling edges, decodes instructions and data writes, and mirrors
// a 16x2 DDRAM plus display state for emulation and driver checking.
module lcd_bus_receiver #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned E_MIN_HIGH   = 2,
  parameter int unsigned CLEAR_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RS,
  input  logic       E,
  input  logic       D0,
  input  logic       D1,
  input  logic       D2,
  input  logic       D3,
  input  logic       D4,
  input  logic       D5,
  input  logic       D6,
  input  logic       D7,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [6:0] cursor_addr,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       inc_mode,
  output logic       busy,
  output logic       cmd_valid,
  output logic       data_valid,
  output logic [7:0] last_byte,
  output logic       overrun,
  output logic       addr_err
);

  localparam int unsigned CntW = (E_MIN_HIGH > 0) ? $clog2(E_MIN_HIGH + 1) : 1;
  // At least 6 bits so the "below 32 cells" compare is representable.
  localparam int unsigned ClrW = ($clog2(CLEAR_CYCLES) > 6) ? $clog2(CLEAR_CYCLES) : 6;

  // Synchronizer chain, packed as {RS, E, D7..D0}.
  logic [9:0] sync_q [SYNC_STAGES];
  logic       rs_s, e_s;
  logic [7:0] d_s;

  // Strobe qualification state.
  logic            e_prev_q;
  logic [CntW-1:0] hi_cnt_q;
  logic            rs_lat_q;
  logic [7:0]      d_lat_q;
  logic            strobe;

  // Display state and pulses.
  logic [6:0]      cursor_q;
  logic            inc_q, disp_q, curs_q, blink_q, busy_q;
  logic [ClrW-1:0] clr_cnt_q;
  logic            cmd_valid_q, data_valid_q, overrun_q, addr_err_q;
  logic [7:0]      last_byte_q;
  logic [7:0]      rd_data_q;

  // DDRAM mirror: cells 0-15 line 1, 16-31 line 2. Deliberately not reset.
  logic [7:0] mem_q [32];
  logic       we;
  logic [4:0] waddr;
  logic [7:0] wdata;

  // Next cursor address with HD44780 two-line wrap.
  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic up);
    logic [6:0] n;
    if (up) begin
      if (a == 7'h27)      n = 7'h40;
      else if (a == 7'h67) n = 7'h00;
      else                 n = a + 7'd1;
    end else begin
      if (a == 7'h00)      n = 7'h67;
      else if (a == 7'h40) n = 7'h27;
      else                 n = a - 7'd1;
    end
    return n;
  endfunction

  // Bring asynchronous bus lines into the clock domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {RS, E, D7, D6, D5, D4, D3, D2, D1, D0};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign rs_s = sync_q[SYNC_STAGES-1][9];
  assign e_s  = sync_q[SYNC_STAGES-1][8];
  assign d_s  = sync_q[SYNC_STAGES-1][7:0];

  // Track E high time and hold the bus values last seen while E was high.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_prev_q <= 1'b0;
      hi_cnt_q <= '0;
      rs_lat_q <= 1'b0;
      d_lat_q  <= '0;
    end else begin
      e_prev_q <= e_s;
      if (e_s) begin
        rs_lat_q <= rs_s;
        d_lat_q  <= d_s;
        if (hi_cnt_q != CntW'(E_MIN_HIGH)) hi_cnt_q <= hi_cnt_q + 1'b1;
      end else begin
        hi_cnt_q <= '0;
      end
    end
  end

  assign strobe = e_prev_q & ~e_s & (hi_cnt_q >= CntW'(E_MIN_HIGH));

  // DDRAM write select: clear fill takes precedence; data strobes are dropped while busy.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (!rst) begin
      if (busy_q) begin
        we    = (clr_cnt_q < ClrW'(32));
        waddr = clr_cnt_q[4:0];
        wdata = 8'h20;
      end else if (strobe && rs_lat_q && (cursor_q[5:0] < 6'd16)) begin
        we    = 1'b1;
        waddr = {cursor_q[6], cursor_q[3:0]};
        wdata = d_lat_q;
      end
    end
  end

  // Instruction/data decode, clear sequencing and registered pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      cursor_q     <= '0;
      inc_q        <= 1'b1;
      disp_q       <= 1'b0;
      curs_q       <= 1'b0;
      blink_q      <= 1'b0;
      busy_q       <= 1'b0;
      clr_cnt_q    <= '0;
      cmd_valid_q  <= 1'b0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      addr_err_q   <= 1'b0;
      last_byte_q  <= '0;
    end else begin
      cmd_valid_q  <= 1'b0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      addr_err_q   <= 1'b0;

      if (busy_q) begin
        if (clr_cnt_q == ClrW'(CLEAR_CYCLES - 1)) begin
          busy_q   <= 1'b0;
          cursor_q <= '0;
          inc_q    <= 1'b1;
        end else begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
        end
      end

      if (strobe) begin
        if (busy_q) begin
          overrun_q <= 1'b1;
        end else begin
          last_byte_q <= d_lat_q;
          if (rs_lat_q) begin
            data_valid_q <= 1'b1;
            cursor_q     <= step_addr(cursor_q, inc_q);
          end else begin
            cmd_valid_q <= 1'b1;
            priority casez (d_lat_q)
              8'b1???????: begin
                if ((d_lat_q[6:0] <= 7'h27) ||
                    ((d_lat_q[6:0] >= 7'h40) && (d_lat_q[6:0] <= 7'h67))) begin
                  cursor_q <= d_lat_q[6:0];
                end else begin
                  cursor_q   <= '0;
                  addr_err_q <= 1'b1;
                end
              end
              8'b01??????: ;  // CGRAM address: no CGRAM modelled
              8'b001?????: ;  // function set: fixed 8-bit, 2-line
              8'b0001????: begin
                if (!d_lat_q[3]) cursor_q <= step_addr(cursor_q, d_lat_q[2]);
              end
              8'b00001???: begin
                disp_q  <= d_lat_q[2];
                curs_q  <= d_lat_q[1];
                blink_q <= d_lat_q[0];
              end
              8'b000001??: inc_q <= d_lat_q[1];
              8'b0000001?: cursor_q <= '0;
              8'b00000001: begin
                busy_q    <= 1'b1;
                clr_cnt_q <= '0;
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  // DDRAM storage.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Registered read port; returns pre-write contents on a same-cycle collision.
  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data     = rd_data_q;
  assign cursor_addr = cursor_q;
  assign disp_on     = disp_q;
  assign cursor_on   = curs_q;
  assign blink_on    = blink_q;
  assign inc_mode    = inc_q;
  assign busy        = busy_q;
  assign cmd_valid   = cmd_valid_q;
  assign data_valid  = data_valid_q;
  assign last_byte   = last_byte_q;
  assign overrun     = overrun_q;
  assign addr_err    = addr_err_q;

endmodule

// File: doc/lcd_bus_receiver.md
Name: lcd_bus_receiver

Overview:
- Synthesizable receiving end of the 8-bit HD44780-style parallel bus (RS, E, D0..D7) driven by the team's LCD writer.
- Samples the bus and captures a byte on each qualified E falling edge.
- Decodes instructions and data writes and mirrors a 16x2 DDRAM plus display state.
- Used as an in-fabric display emulator and as a checker for LCD driver blocks.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on RS/E/D inputs (min 2)
- E_MIN_HIGH, 2, minimum consecutive synchronized-high cycles of E for its falling edge to count
- CLEAR_CYCLES, 32, cycles spent filling DDRAM with 0x20 on Clear Display (one cell per cycle)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- RS  in  1  register select (0 = instruction, 1 = data)
- E  in  1  enable strobe; byte latched on its falling edge
- D0..D7  in  1 each  data bus (D7 = MSB)
- rd_addr  in  5  read index: 0-15 = line 1, 16-31 = line 2
- rd_data  out  8  DDRAM byte at rd_addr, registered, 1-cycle latency
- cursor_addr  out  7  current DDRAM address (HD44780 encoding)
- disp_on, cursor_on, blink_on  out  1 each  from Display Control
- inc_mode  out  1  entry-mode I/D bit
- busy  out  1  high while a clear is in progress
- cmd_valid  out  1  one-cycle pulse per accepted instruction byte
- data_valid  out  1  one-cycle pulse per accepted data byte
- last_byte  out  8  most recently captured byte
- overrun  out  1  one-cycle pulse when a byte arrives while busy
- addr_err  out  1  one-cycle pulse on Set DDRAM Address with an invalid address

Behaviour:
- Reset (synchronous):
  - Outputs: cursor_addr=0x00, inc_mode=1, disp_on=0, cursor_on=0, blink_on=0, busy=0, all pulses 0, last_byte=0x00, rd_data=0x00.
  - E high-counter cleared.
  - DDRAM not cleared by reset; contents undefined until the first Clear Display.
  - Reset mid-clear aborts the clear immediately and drops busy.
- Sampling and strobe qualification:
  - RS/E/D pass through SYNC_STAGES flops.
  - While synchronized E is high, RS and D are registered every cycle and a saturating high-counter increments.
  - Falling edge (E synced 1 -> 0) with counter >= E_MIN_HIGH yields one strobe using the last values registered while E was high. Shorter pulses are ignored silently.
  - Capture-to-pulse latency: cmd_valid/data_valid assert exactly 1 cycle after the falling edge is seen at the synchronizer output. last_byte updates in that same cycle.
- Decode, RS=0 (priority by leading one):
  - 1aaaaaaa Set DDRAM address:
    - Valid ranges 0x00-0x27 and 0x40-0x67 load cursor_addr.
    - Any other value sets cursor_addr=0x00 and pulses addr_err.
  - 01xxxxxx Set CGRAM address: accepted, no state change.
  - 001xxxxx Function set: accepted, no state change.
  - 0001 SC RL xx:
    - SC=0: cursor moves +1 (RL=1) or -1 (RL=0) with the wrap rules below.
    - SC=1: no change.
  - 00001 D C B: disp_on=D, cursor_on=C, blink_on=B.
  - 000001 ID S: inc_mode=ID; S ignored.
  - 0000001x Return home: cursor_addr=0x00.
  - 00000001 Clear display:
    - busy=1 for CLEAR_CYCLES cycles; writes 0x20 to cells 0..31, one per cycle.
    - Then cursor_addr=0x00, inc_mode=1.
  - 00000000: accepted, no effect.
- Data, RS=1:
  - If cursor column (addr[5:0]) < 16, write byte to cell (addr[6] ? 16 : 0) + addr[3:0].
  - Columns 16-39 are not stored.
  - cursor_addr then steps per inc_mode.
- Address wrap:
  - Increment: 0x27 -> 0x40, 0x67 -> 0x00.
  - Decrement: 0x00 -> 0x67, 0x40 -> 0x27.
- Busy:
  - A strobe arriving while busy=1 is discarded, pulses overrun, and does not assert cmd_valid/data_valid or update last_byte.
- Read port:
  - Independent of writes. Same-cycle write and read of the same cell returns the old value.
  - rd_data valid the cycle after rd_addr is presented.

Test Plan:
- Reset check: assert rst 2 cycles -> cursor_addr=0x00, inc_mode=1, busy=0, disp_on=0; then send 0x0F -> disp_on=cursor_on=blink_on=1, one cmd_valid pulse.
- Clear timing: send 0x01 -> busy high exactly 32 cycles; afterwards rd_addr 0..31 all return 0x20; cursor_addr=0x00.
- Addressed write: send 0xC0 then data 0x48 -> cursor_addr 0x40 -> 0x41; rd_addr=16 returns 0x48 one cycle later; one data_valid pulse; last_byte=0x48.
- Wrap: set address 0x27, write 0x41 -> cursor_addr=0x40, no cell written; send 0x04 (decrement), set 0x00, write -> cursor_addr=0x67.
- Glitch filter and overrun:
  - E high for 1 synced cycle -> no pulse.
  - Valid data strobe during clear -> overrun pulse, DDRAM still all 0x20 at end.
- Error and abort:
  - Send 0xB0 -> addr_err pulse, cursor_addr=0x00.
  - Assert rst at cycle 10 of a clear -> busy=0 the following cycle; the next strobe is accepted normally.
